// File: rtl/audio_pkg.sv
// Shared definitions for the audio capture path.
package audio_pkg;

    localparam int unsigned DATA_WIDTH_DEF  = 16;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } rx_state_t;

    localparam logic LRC_LEFT  = 1'b0;
    localparam logic LRC_RIGHT = 1'b1;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with optional rise detect.
module sync_edge #(
    parameter int unsigned STAGES = 2,
    parameter bit          EDGE   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise_c
);

    logic [STAGES-1:0] chain;

    // Synchroniser shift chain; the last stage is the usable value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

    generate
        if (EDGE) begin : g_edge
            logic q_d;

            // Previous synchronised value for rise detection.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    q_d <= 1'b0;
                end else begin
                    q_d <= q;
                end
            end

            assign rise_c = q & ~q_d;
        end else begin : g_no_edge
            assign rise_c = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/i2s_rx_sync.sv
// Oversampling I2S receiver: deserialises ADC frames into aligned stereo pairs.
module i2s_rx_sync
    import audio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  BCLK,
    input  logic                  ADCLRC,
    input  logic                  ADCDAT,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  sample_valid,
    output logic                  frame_err
);

    localparam int unsigned        CNT_W    = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic                  bclk_s;
    logic                  brise;
    logic                  lrc_s;
    logic                  dat_s;
    logic [1:0]            unused_rise;
    logic                  lrc_edge_c;
    logic [DATA_WIDTH-1:0] word_c;

    rx_state_t             state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic [DATA_WIDTH-1:0] left_hold, left_hold_n;
    logic                  left_pending, left_pending_n;
    logic                  chan, chan_n;
    logic                  lrc_prev;
    logic [DATA_WIDTH-1:0] left_n, right_n;
    logic                  valid_n;
    logic                  err_set;

    sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b1)) u_sync_bclk (
        .clk(clk), .reset_n(reset_n), .d(BCLK), .q(bclk_s), .rise_c(brise)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b0)) u_sync_lrc (
        .clk(clk), .reset_n(reset_n), .d(ADCLRC), .q(lrc_s), .rise_c(unused_rise[0])
    );
    sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b0)) u_sync_dat (
        .clk(clk), .reset_n(reset_n), .d(ADCDAT), .q(dat_s), .rise_c(unused_rise[1])
    );

    assign lrc_edge_c = brise & (lrc_s != lrc_prev);
    assign word_c     = {shreg[DATA_WIDTH-2:0], dat_s};

    // Next-state, datapath and output decode.
    // The edge bit itself is the I2S delay slot: SKIP lasts one clk and hands
    // over to SHIFT before the next BCLK rise, so the following bit is the MSB.
    // This lets the final data bit of a 16-bit slot coincide with the next edge.
    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        shreg_n        = shreg;
        left_hold_n    = left_hold;
        left_pending_n = left_pending;
        chan_n         = chan;
        left_n         = left_data;
        right_n        = right_data;
        valid_n        = 1'b0;
        err_set        = 1'b0;

        if (!enable) begin
            state_n        = IDLE;
            left_pending_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (lrc_edge_c) begin
                        state_n = SKIP;
                        chan_n  = lrc_s;
                    end
                end
                SKIP: begin
                    state_n = SHIFT;
                    cnt_n   = '0;
                end
                SHIFT: begin
                    if (brise) begin
                        if (lrc_edge_c && (cnt != LAST_BIT)) begin
                            err_set        = 1'b1;
                            left_pending_n = 1'b0;
                            state_n        = SKIP;
                            chan_n         = lrc_s;
                        end else begin
                            shreg_n = word_c;
                            cnt_n   = CNT_W'(cnt + 1'b1);
                            if (cnt == LAST_BIT) begin
                                if (chan == LRC_LEFT) begin
                                    left_hold_n    = word_c;
                                    left_pending_n = 1'b1;
                                end else if (chan == LRC_RIGHT && left_pending) begin
                                    left_n         = left_hold;
                                    right_n        = word_c;
                                    left_pending_n = 1'b0;
                                    valid_n        = 1'b1;
                                end else begin
                                    err_set = 1'b1;
                                end
                                state_n = lrc_edge_c ? SKIP : HOLD;
                                if (lrc_edge_c) begin
                                    chan_n = lrc_s;
                                end
                            end
                        end
                    end
                end
                HOLD: begin
                    if (lrc_edge_c) begin
                        state_n = SKIP;
                        chan_n  = lrc_s;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath and registered outputs; a new error wins over err_clr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            shreg        <= '0;
            left_hold    <= '0;
            left_pending <= 1'b0;
            chan         <= 1'b0;
            lrc_prev     <= 1'b0;
            left_data    <= '0;
            right_data   <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            cnt          <= cnt_n;
            shreg        <= shreg_n;
            left_hold    <= left_hold_n;
            left_pending <= left_pending_n;
            chan         <= chan_n;
            if (brise) begin
                lrc_prev <= lrc_s;
            end
            left_data    <= left_n;
            right_data   <= right_n;
            sample_valid <= valid_n;
            frame_err    <= err_set ? 1'b1 : (err_clr ? 1'b0 : frame_err);
        end
    end

endmodule

// File: tb/tb_i2s_rx_sync.sv
// Randomised directed bench for i2s_rx_sync with a word-level reference model.
module tb_i2s_rx_sync;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          BCLK;
    logic          ADCLRC;
    logic          ADCDAT;
    logic          err_clr;
    logic [DW-1:0] left_data;
    logic [DW-1:0] right_data;
    logic          sample_valid;
    logic          frame_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: position within the current word, pairing, error.
    bit            lrc_prev_m, in_word, done_m, chan_m, pending_m, err_m, en_m;
    int            pos_m;
    logic [DW-1:0] word_m, hold_m;
    logic [DW-1:0] exp_l[$];
    logic [DW-1:0] exp_r[$];
    logic [DW-1:0] cur_l, cur_r;

    // Pin stream under construction.
    bit lrc_q[$];
    bit dat_q[$];

    i2s_rx_sync #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .BCLK(BCLK),
        .ADCLRC(ADCLRC), .ADCDAT(ADCDAT), .err_clr(err_clr),
        .left_data(left_data), .right_data(right_data),
        .sample_valid(sample_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        lrc_prev_m = 1'b0; in_word = 1'b0; done_m = 1'b0; chan_m = 1'b0;
        pending_m = 1'b0; err_m = 1'b0; pos_m = 0; word_m = '0; hold_m = '0;
        exp_l.delete(); exp_r.delete();
    endfunction

    function automatic void complete_word();
        if (chan_m == 1'b0) begin
            hold_m    = word_m;
            pending_m = 1'b1;
        end else if (pending_m) begin
            exp_l.push_back(hold_m);
            exp_r.push_back(word_m);
            pending_m = 1'b0;
        end else begin
            err_m = 1'b1;
        end
    endfunction

    // A word's bits are the DW bits following the LRC edge bit.
    function automatic void model_bit(input bit l, input bit d);
        bit is_edge;
        is_edge    = (l != lrc_prev_m);
        lrc_prev_m = l;
        if (!en_m) return;
        if (is_edge) begin
            if (in_word && !done_m) begin
                if (pos_m == DW - 1) begin
                    word_m = DW'((word_m << 1) | DW'(d));
                    complete_word();
                end else begin
                    err_m     = 1'b1;
                    pending_m = 1'b0;
                end
            end
            in_word = 1'b1; done_m = 1'b0; pos_m = 0; chan_m = l; word_m = '0;
        end else if (in_word && !done_m) begin
            word_m = DW'((word_m << 1) | DW'(d));
            pos_m++;
            if (pos_m == DW) begin
                complete_word();
                done_m = 1'b1;
            end
        end
    endfunction

    // One BCLK period: data changes on the fall, the receiver samples on the rise.
    task automatic send_bit(input bit l, input bit d);
        @(negedge clk);
        BCLK = 1'b0; ADCLRC = l; ADCDAT = d;
        repeat (8) @(negedge clk);
        BCLK = 1'b1;
        model_bit(l, d);
        repeat (7) @(negedge clk);
    endtask

    task automatic add_idle(input bit l, input int n);
        for (int k = 0; k < n; k++) begin
            lrc_q.push_back(l);
            if (dat_q.size() < lrc_q.size()) dat_q.push_back(bit'($urandom_range(0, 1)));
        end
    endtask

    // One channel slot; the MSB follows the slot's first bit, excess bits are junk.
    task automatic add_half(input bit chan, input logic [DW-1:0] w, input int slot);
        int s;
        s = lrc_q.size();
        add_idle(chan, slot);
        for (int j = 0; j < DW; j++) begin
            int idx;
            idx = s + 1 + j;
            if (idx <= s + slot) begin
                while (dat_q.size() <= idx) dat_q.push_back(bit'($urandom_range(0, 1)));
                dat_q[idx] = w[DW-1-j];
            end
        end
    endtask

    task automatic flush(input int tail);
        int n;
        bit last_l;
        n = ((dat_q.size() > lrc_q.size()) ? dat_q.size() : lrc_q.size()) + tail;
        last_l = (lrc_q.size() > 0) ? lrc_q[lrc_q.size()-1] : bit'(ADCLRC);
        while (lrc_q.size() < n) lrc_q.push_back(last_l);
        while (dat_q.size() < n) dat_q.push_back(bit'($urandom_range(0, 1)));
        for (int i = 0; i < n; i++) send_bit(lrc_q[i], dat_q[i]);
        lrc_q.delete(); dat_q.delete();
    endtask

    task automatic send_prefix(input int n);
        for (int i = 0; i < n; i++) send_bit(lrc_q[i], dat_q[i]);
        lrc_q.delete(); dat_q.delete();
    endtask

    task automatic check_idle(input string tag);
        repeat (24) @(negedge clk);
        chk({tag, "_pulses_outstanding"}, 32'(exp_l.size()), 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'(err_m));
        chk({tag, "_left"}, 32'(left_data), 32'(cur_l));
        chk({tag, "_right"}, 32'(right_data), 32'(cur_r));
    endtask

    task automatic clear_err();
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        err_m = 1'b0;
    endtask

    task automatic set_enable(input bit e);
        @(negedge clk);
        enable = e; en_m = e;
        if (!e) begin
            in_word = 1'b0; pending_m = 1'b0;
        end
    endtask

    // Output monitor: each pulse must match the model, outputs hold otherwise.
    initial begin
        bit prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                cur_l = '0; cur_r = '0; prev_v = 1'b0;
            end else begin
                if (sample_valid) begin
                    chk("valid_back_to_back", 32'(prev_v), 32'd0);
                    chk("pulse_expected", 32'(exp_l.size() > 0), 32'd1);
                    if (exp_l.size() > 0) begin
                        cur_l = exp_l.pop_front();
                        cur_r = exp_r.pop_front();
                    end
                    chk("left_data", 32'(left_data), 32'(cur_l));
                    chk("right_data", 32'(right_data), 32'(cur_r));
                end else begin
                    chk("left_hold", 32'(left_data), 32'(cur_l));
                    chk("right_hold", 32'(right_data), 32'(cur_r));
                end
                prev_v = sample_valid;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0; BCLK = 1'b0; ADCLRC = 1'b0; ADCDAT = 1'b0; err_clr = 1'b0;
        model_reset();
        en_m = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_left", 32'(left_data), 32'd0);
        chk("reset_right", 32'(right_data), 32'd0);
        chk("reset_valid", 32'(sample_valid), 32'd0);
        chk("reset_err", 32'(frame_err), 32'd0);
        reset_n = 1'b1; enable = 1'b1;
        repeat (4) @(negedge clk);

        // Partial right word at start-up, then a clean 16-bit-slot frame.
        add_idle(1'b0, 3);
        add_half(1'b1, 16'($urandom), 6);
        add_half(1'b0, 16'hA5C3, 16);
        add_half(1'b1, 16'h0F01, 16);
        flush(3);
        check_idle("t1");
        chk("t1_pair_left", 32'(cur_l), 32'h0000A5C3);
        chk("t1_pair_right", 32'(cur_r), 32'h00000F01);
        clear_err();
        check_idle("t1_clr");

        // 32-bit slots with junk after each 16-bit word.
        add_half(1'b0, 16'h8001, 32);
        add_half(1'b1, 16'h7FFE, 32);
        check_idle("t2_pre");
        flush(2);
        check_idle("t2a");
        add_half(1'b0, 16'($urandom), 32);
        add_half(1'b1, 16'($urandom), 32);
        flush(2);
        check_idle("t2b");

        // Short left word, orphan right word, then a clean frame.
        add_half(1'b0, 16'($urandom), 10);
        add_half(1'b1, 16'($urandom), 16);
        add_half(1'b0, 16'h1234, 16);
        add_half(1'b1, 16'h5678, 16);
        flush(2);
        check_idle("t3");
        chk("t3_err_sticky", 32'(frame_err), 32'd1);
        clear_err();
        check_idle("t3_clr");

        // Stream beginning on the right channel.
        set_enable(1'b0);
        add_idle(1'b0, 3);
        flush(0);
        set_enable(1'b1);
        add_half(1'b1, 16'($urandom), 16);
        add_half(1'b0, 16'($urandom), 16);
        add_half(1'b1, 16'($urandom), 16);
        flush(2);
        check_idle("t4");
        clear_err();

        // Reset in the middle of a right word.
        add_half(1'b0, 16'($urandom), 16);
        add_half(1'b1, 16'($urandom), 16);
        send_prefix(24);
        @(negedge clk); BCLK = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("t5_reset_left", 32'(left_data), 32'd0);
        chk("t5_reset_right", 32'(right_data), 32'd0);
        chk("t5_reset_valid", 32'(sample_valid), 32'd0);
        chk("t5_reset_err", 32'(frame_err), 32'd0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        add_half(1'b1, 16'($urandom), 16);
        add_half(1'b0, 16'($urandom), 16);
        add_half(1'b1, 16'($urandom), 16);
        add_half(1'b0, 16'($urandom), 16);
        add_half(1'b1, 16'($urandom), 16);
        flush(2);
        check_idle("t5");
        clear_err();

        // Disabled for three frames, then resume.
        set_enable(1'b0);
        for (int f = 0; f < 3; f++) begin
            add_half(1'b0, 16'($urandom), 16);
            add_half(1'b1, 16'($urandom), 16);
        end
        flush(0);
        check_idle("t6_off");
        set_enable(1'b1);
        for (int f = 0; f < 2; f++) begin
            add_half(1'b0, 16'($urandom), 16);
            add_half(1'b1, 16'($urandom), 16);
        end
        flush(2);
        check_idle("t6_on");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
